// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing one uart_tx among NUM_REQ byte streams.
// Optional UART_ARB_TAG_EN: sends tag byte 8'hF0|id ahead of each newly granted packet.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    input  logic                   tx_busy,
    output logic                   timeout
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_HI, WAIT_LO} state_t;

    state_t               state_q;
    logic [IW-1:0]        ptr_q;
    logic [IW-1:0]        gidx_q;
    logic                 last_q;
    logic [CW-1:0]        cnt_q;
    logic [NUM_REQ-1:0]   grant_q;
    logic [NUM_REQ-1:0]   req_ready_q;
    logic                 tx_start_q;
    logic [7:0]           tx_data_q;
    logic                 timeout_q;
`ifdef UART_ARB_TAG_EN
    logic                 tag_q;
`endif

    logic                 pick_found_d;
    logic [IW-1:0]        pick_idx_d;
    logic [IW-1:0]        ptr_d;

    // Scan downwards so the lowest offset from ptr wins.
    always_comb begin
        pick_found_d = 1'b0;
        pick_idx_d   = ptr_q;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(ptr_q) + k) % NUM_REQ]) begin
                pick_found_d = 1'b1;
                pick_idx_d   = IW'((int'(ptr_q) + k) % NUM_REQ);
            end
        end
        ptr_d = (gidx_q == IW'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gidx_q      <= '0;
            last_q      <= 1'b0;
            cnt_q       <= '0;
            grant_q     <= '0;
            req_ready_q <= '0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            timeout_q   <= 1'b0;
`ifdef UART_ARB_TAG_EN
            tag_q       <= 1'b0;
`endif
        end else begin
            req_ready_q <= '0;
            tx_start_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_found_d) begin
                        grant_q <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx_d;
                        gidx_q  <= pick_idx_d;
`ifdef UART_ARB_TAG_EN
                        tag_q   <= 1'b1;
`endif
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
`ifdef UART_ARB_TAG_EN
                    if (!tx_busy && tag_q) begin
                        tx_data_q <= 8'hF0 | 8'(gidx_q);
                        last_q    <= 1'b0;
                        tag_q     <= 1'b0;
                        state_q   <= START;
                    end else
`endif
                    if (!tx_busy && req_valid[gidx_q]) begin
                        tx_data_q   <= req_data[8*gidx_q +: 8];
                        req_ready_q <= grant_q;
                        last_q      <= req_last[gidx_q];
                        state_q     <= START;
                    end
                end
                START: begin
                    tx_start_q <= 1'b1;
                    cnt_q      <= '0;
                    state_q    <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (tx_busy) begin
                        state_q <= WAIT_LO;
                    end else if (cnt_q == CW'(BUSY_TIMEOUT - 1)) begin
                        timeout_q <= 1'b1;
                        state_q   <= WAIT_LO;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                WAIT_LO: begin
                    if (!tx_busy) begin
                        if (last_q) begin
                            grant_q <= '0;
                            ptr_q   <= ptr_d;
                            state_q <= IDLE;
                        end else begin
                            state_q <= LOAD;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign grant     = grant_q;
    assign tx_start  = tx_start_q;
    assign tx_data   = tx_data_q;
    assign timeout   = timeout_q;
endmodule
